// File: rtl/jpeg_dqt_parse_if.sv
// Byte-stream input and table-RAM write port of the DQT segment parser.
// The master modport belongs to the header stream side, the slave modport to the parser.
interface jpeg_dqt_parse_if;
  logic       Start;
  logic       DataInEnable;
  logic [7:0] DataIn;
  logic       DataInRead;
  logic       DqtEnable;
  logic       DqtColor;
  logic [5:0] DqtCount;
  logic [7:0] DqtData;
  logic       DqtDone;
  logic       DqtError;

  modport master (
    output Start, DataInEnable, DataIn,
    input  DataInRead, DqtEnable, DqtColor, DqtCount, DqtData, DqtDone, DqtError
  );

  modport slave (
    input  Start, DataInEnable, DataIn,
    output DataInRead, DqtEnable, DqtColor, DqtCount, DqtData, DqtDone, DqtError
  );
endinterface

// File: rtl/jpeg_dqt_parse.sv
// DQT (FFDB) segment payload parser: validates Lq/Pq/Tq and emits one
// registered write strobe per quantizer byte toward the Y/C table RAMs.
module jpeg_dqt_parse #(
  parameter int unsigned TQ_MAX = 32'd1
) (
  input logic              clk,
  input logic              rst,
  jpeg_dqt_parse_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN_H = 3'd1,
    LEN_L = 3'd2,
    PQTQ  = 3'd3,
    TABLE = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  state_t      state_r;
  state_t      stateNext_s;
  logic        dataInRead_s;
  logic        xfer_s;
  logic [15:0] lq_s;
  logic        pqtqBad_s;

  logic [7:0]  lenHi_r;
  logic [15:0] remain_r;
  logic        color_r;
  logic [5:0]  count_r;
  logic        dqtEnable_r;
  logic        dqtColor_r;
  logic [5:0]  dqtCount_r;
  logic [7:0]  dqtData_r;
  logic        dqtDone_r;
  logic        dqtError_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode, byte acceptance and segment field checks.
  always_comb begin
    stateNext_s  = state_r;
    dataInRead_s = 1'b0;
    lq_s         = {lenHi_r, bus.DataIn};
    // The remaining-length test must happen before the subtract so Remain never wraps.
    pqtqBad_s    = (bus.DataIn[7:4] != 4'd0) ||
                   (32'(bus.DataIn[3:0]) > TQ_MAX) ||
                   (remain_r < 16'd65);

    case (state_r)
      LEN_H, LEN_L, PQTQ, TABLE: dataInRead_s = ~bus.Start;
      IDLE, DONE, ERROR:         dataInRead_s = 1'b0;
      default:                   dataInRead_s = 1'b0;
    endcase

    xfer_s = bus.DataInEnable & dataInRead_s;

    if (bus.Start) begin
      stateNext_s = LEN_H;
    end else begin
      case (state_r)
        IDLE: stateNext_s = IDLE;
        LEN_H: begin
          if (xfer_s) stateNext_s = LEN_L;
          else        stateNext_s = LEN_H;
        end
        LEN_L: begin
          if (!xfer_s)              stateNext_s = LEN_L;
          else if (lq_s < 16'd2)    stateNext_s = ERROR;
          else if (lq_s == 16'd2)   stateNext_s = DONE;
          else                      stateNext_s = PQTQ;
        end
        PQTQ: begin
          if (!xfer_s)      stateNext_s = PQTQ;
          else if (pqtqBad_s) stateNext_s = ERROR;
          else              stateNext_s = TABLE;
        end
        TABLE: begin
          if (!xfer_s || (count_r != 6'd63)) stateNext_s = TABLE;
          else if (remain_r == 16'd0)        stateNext_s = DONE;
          else                               stateNext_s = PQTQ;
        end
        DONE:    stateNext_s = IDLE;
        ERROR:   stateNext_s = ERROR;
        default: stateNext_s = IDLE;
      endcase
    end
  end

  // Segment bookkeeping plus registered table-write and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lenHi_r     <= 8'd0;
      remain_r    <= 16'd0;
      color_r     <= 1'b0;
      count_r     <= 6'd0;
      dqtEnable_r <= 1'b0;
      dqtColor_r  <= 1'b0;
      dqtCount_r  <= 6'd0;
      dqtData_r   <= 8'd0;
      dqtDone_r   <= 1'b0;
      dqtError_r  <= 1'b0;
    end else begin
      dqtEnable_r <= 1'b0;
      dqtDone_r   <= (state_r == DONE) && !bus.Start;

      if (bus.Start) begin
        dqtError_r <= 1'b0;
      end else if (stateNext_s == ERROR) begin
        dqtError_r <= 1'b1;
      end

      if (xfer_s) begin
        case (state_r)
          LEN_H: lenHi_r <= bus.DataIn;
          LEN_L: begin
            if (lq_s > 16'd2) remain_r <= lq_s - 16'd2;
          end
          PQTQ: begin
            if (!pqtqBad_s) begin
              remain_r <= remain_r - 16'd65;
              color_r  <= bus.DataIn[0];
              count_r  <= 6'd0;
            end
          end
          TABLE: begin
            dqtEnable_r <= 1'b1;
            dqtData_r   <= bus.DataIn;
            dqtCount_r  <= count_r;
            dqtColor_r  <= color_r;
            count_r     <= count_r + 6'd1;
          end
          default: lenHi_r <= lenHi_r;
        endcase
      end
    end
  end

  assign bus.DataInRead = dataInRead_s;
  assign bus.DqtEnable  = dqtEnable_r;
  assign bus.DqtColor   = dqtColor_r;
  assign bus.DqtCount   = dqtCount_r;
  assign bus.DqtData    = dqtData_r;
  assign bus.DqtDone    = dqtDone_r;
  assign bus.DqtError   = dqtError_r;

endmodule

// File: tb/tb_jpeg_dqt_parse.sv
// Scoreboard bench for jpeg_dqt_parse: table bytes queue an expected strobe
// when accepted; the strobe monitor pops and compares them.
module tb_jpeg_dqt_parse;

  typedef struct {
    logic [7:0] b;
    bit         tab;
    logic       col;
    logic [5:0] cnt;
  } stim_t;

  typedef struct {
    logic       col;
    logic [5:0] cnt;
    logic [7:0] dat;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jpeg_dqt_parse_if bus ();

  jpeg_dqt_parse #(.TQ_MAX(32'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  stim_t stimQ[$];
  exp_t  expQ[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobeCnt = 0;
  int doneCnt = 0;
  int lastStrobeCyc = 0;
  int lastDoneCyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Strobe and done monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.DqtEnable === 1'b1) begin
      strobeCnt++;
      lastStrobeCyc = cyc;
      if (expQ.size() == 0) begin
        chk("strobe_unexpected", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        chk("strobe_color", 32'(bus.DqtColor), 32'(e.col));
        chk("strobe_count", 32'(bus.DqtCount), 32'(e.cnt));
        chk("strobe_data", 32'(bus.DqtData), 32'(e.dat));
        chk("strobe_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (bus.DqtDone === 1'b1) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic addB(input logic [7:0] b);
    stim_t s;
    s.b = b; s.tab = 1'b0; s.col = 1'b0; s.cnt = 6'd0;
    stimQ.push_back(s);
  endtask

  task automatic addTab(input logic col, input int n, input logic [7:0] base);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s.b = 8'(base + 8'(k)); s.tab = 1'b1; s.col = col; s.cnt = 6'(k);
      stimQ.push_back(s);
    end
  endtask

  task automatic addCase1(input logic [7:0] base);
    addB(8'h00); addB(8'h43); addB(8'h00);
    addTab(1'b0, 64, base);
  endtask

  task automatic addCase2();
    addB(8'h00); addB(8'h84); addB(8'h00);
    addTab(1'b0, 64, 8'h01);
    addB(8'h01);
    addTab(1'b1, 64, 8'hA0);
  endtask

  // Entered and left at posedge+1.
  task automatic driveSeg(input int gapPct);
    stim_t s;
    exp_t  e;
    bit    accepted;
    int    tries;
    int    gaps;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      gaps = 0;
      while (gapPct > 0 && gaps < 8 && $urandom_range(99) < gapPct) begin
        bus.DataInEnable = 1'b0;
        bus.DataIn = 8'($urandom);
        @(posedge clk); #1;
        gaps++;
      end
      bus.DataInEnable = 1'b1;
      bus.DataIn = s.b;
      accepted = 1'b0;
      tries = 0;
      while (!accepted && tries < 50) begin
        @(negedge clk);
        if (bus.DataInRead === 1'b1) begin
          accepted = 1'b1;
          if (s.tab) begin
            e.col = s.col; e.cnt = s.cnt; e.dat = s.b; e.due = cyc + 1;
            expQ.push_back(e);
          end
        end
        @(posedge clk); #1;
        tries++;
      end
      if (!accepted) begin
        chk("xfer_timeout", 32'(accepted), 32'd1);
        stimQ.delete();
      end
    end
    bus.DataInEnable = 1'b0;
  endtask

  task automatic doStart();
    bus.Start = 1'b1;
    bus.DataInEnable = 1'b1;
    bus.DataIn = 8'hFF;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.DataInEnable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int s0;
  int d0;

  initial begin
    bus.Start = 1'b0;
    bus.DataInEnable = 1'b0;
    bus.DataIn = 8'h00;
    #23 rst = 1'b0;
    @(negedge clk);
    chk("rst_read", 32'(bus.DataInRead), 32'd0);
    chk("rst_enable", 32'(bus.DqtEnable), 32'd0);
    chk("rst_color", 32'(bus.DqtColor), 32'd0);
    chk("rst_count", 32'(bus.DqtCount), 32'd0);
    chk("rst_data", 32'(bus.DqtData), 32'd0);
    chk("rst_done", 32'(bus.DqtDone), 32'd0);
    chk("rst_error", 32'(bus.DqtError), 32'd0);
    @(posedge clk); #1;

    // Case 1: single Y table.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addCase1(8'h01);
    driveSeg(0);
    idle(3);
    chk("t1_strobes", 32'(strobeCnt - s0), 32'd64);
    chk("t1_done", 32'(doneCnt - d0), 32'd1);
    chk("t1_done_lat", 32'(lastDoneCyc), 32'(lastStrobeCyc + 1));
    chk("t1_error", 32'(bus.DqtError), 32'd0);

    // Case 2: Y then C table in one segment.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addCase2();
    driveSeg(0);
    idle(3);
    chk("t2_strobes", 32'(strobeCnt - s0), 32'd128);
    chk("t2_done", 32'(doneCnt - d0), 32'd1);
    chk("t2_error", 32'(bus.DqtError), 32'd0);

    // Case 3: same segment with random valid gaps.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addCase2();
    driveSeg(50);
    idle(3);
    chk("t3_strobes", 32'(strobeCnt - s0), 32'd128);
    chk("t3_done", 32'(doneCnt - d0), 32'd1);

    // Case 4: Pq=1 rejected, then recovery via Start.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addB(8'h00); addB(8'h43); addB(8'h10);
    driveSeg(0);
    idle(2);
    @(negedge clk);
    chk("t4_error", 32'(bus.DqtError), 32'd1);
    chk("t4_read", 32'(bus.DataInRead), 32'd0);
    chk("t4_strobes", 32'(strobeCnt - s0), 32'd0);
    chk("t4_done", 32'(doneCnt - d0), 32'd0);
    @(posedge clk); #1;
    doStart();
    @(negedge clk);
    chk("t4_error_clr", 32'(bus.DqtError), 32'd0);
    @(posedge clk); #1;
    s0 = strobeCnt; d0 = doneCnt;
    addCase1(8'h01);
    driveSeg(0);
    idle(3);
    chk("t4_recover_strobes", 32'(strobeCnt - s0), 32'd64);
    chk("t4_recover_done", 32'(doneCnt - d0), 32'd1);

    // Case 5: trailing byte leaves Remain=1 at PQTQ -> error; then Lq=2.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addB(8'h00); addB(8'h44); addB(8'h00);
    addTab(1'b0, 64, 8'h30);
    addB(8'h00);
    driveSeg(0);
    idle(2);
    chk("t5_strobes", 32'(strobeCnt - s0), 32'd64);
    chk("t5_error", 32'(bus.DqtError), 32'd1);
    chk("t5_done", 32'(doneCnt - d0), 32'd0);
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addB(8'h00); addB(8'h02);
    driveSeg(0);
    idle(3);
    chk("t5_lq2_done", 32'(doneCnt - d0), 32'd1);
    chk("t5_lq2_strobes", 32'(strobeCnt - s0), 32'd0);
    chk("t5_lq2_error", 32'(bus.DqtError), 32'd0);

    // Case 6a: async reset after 10 table bytes.
    doStart();
    addB(8'h00); addB(8'h43); addB(8'h00);
    addTab(1'b0, 10, 8'h50);
    driveSeg(0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_enable", 32'(bus.DqtEnable), 32'd0);
    chk("t6_rst_count", 32'(bus.DqtCount), 32'd0);
    chk("t6_rst_data", 32'(bus.DqtData), 32'd0);
    chk("t6_rst_read", 32'(bus.DataInRead), 32'd0);
    expQ.delete();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    s0 = strobeCnt;
    idle(2);
    chk("t6_rst_no_strobe", 32'(strobeCnt - s0), 32'd0);

    // Case 6b: Start mid-table at count 20 restarts at count 0.
    s0 = strobeCnt; d0 = doneCnt;
    doStart();
    addB(8'h00); addB(8'h43); addB(8'h00);
    addTab(1'b0, 20, 8'h40);
    driveSeg(0);
    doStart();
    addCase1(8'h80);
    driveSeg(0);
    idle(3);
    chk("t6_abort_strobes", 32'(strobeCnt - s0), 32'd84);
    chk("t6_abort_done", 32'(doneCnt - d0), 32'd1);

    idle(2);
    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
